// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline freeze/flush sequencer.
// Optional feature macro used elsewhere: HAZARD_PERF_CNT_EN.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int          REG_W_DEF = 4;
  localparam logic [31:0] BUBBLE    = 32'b0;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline status in, freeze/flush controls out.
// master = pipeline side driving status, slave = the controller.
interface pipeline_hazard_controller_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
);
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_used;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             fwd_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             ifid_freeze;
  logic             idexe_freeze;
  logic             exemem_freeze;
  logic             ifid_flush;
  logic             idexe_flush;
  logic             memwb_flush;
  logic             mem_error;

  modport master (
    output id_src1, id_src2, id_src2_used, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
    input  pc_freeze, ifid_freeze, idexe_freeze, exemem_freeze,
           ifid_flush, idexe_flush, memwb_flush, mem_error
  );

  modport slave (
    input  id_src1, id_src2, id_src2_used, exe_dest, exe_wb_en, exe_mem_read,
           mem_dest, mem_wb_en, fwd_en, branch_taken, mem_req, mem_ready,
    output pc_freeze, ifid_freeze, idexe_freeze, exemem_freeze,
           ifid_flush, idexe_flush, memwb_flush, mem_error
  );
endinterface

// File: rtl/pipeline_hazard_controller_detect.sv
// Combinational RAW comparator: decode sources against EXE/MEM destinations.
// With forwarding only a load in EXE can hazard; without it any pending writer does.
module hazard_detect
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_src2_used_i,
  input  logic [REG_W-1:0] exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_read_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             fwd_en_i,
  output logic             hazard_o
);
  logic exe_hit;
  logic mem_hit;

  assign exe_hit = exe_wb_en_i &&
                   ((id_src1_i == exe_dest_i) || (id_src2_used_i && (id_src2_i == exe_dest_i)));
  assign mem_hit = mem_wb_en_i &&
                   ((id_src1_i == mem_dest_i) || (id_src2_used_i && (id_src2_i == mem_dest_i)));

  assign hazard_o = fwd_en_i ? (exe_hit && exe_mem_read_i) : (exe_hit || mem_hit);
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Freeze/flush sequencer: arbitrates memory stall > taken branch > data hazard each cycle,
// with a MEM_WAIT timeout into a sticky ERROR. HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipeline_hazard_controller
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_hazard_controller_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flush_events
`endif
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hazard;
  logic             stall_all, br_flush, data_stall;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_src1_i      (hz.id_src1),
    .id_src2_i      (hz.id_src2),
    .id_src2_used_i (hz.id_src2_used),
    .exe_dest_i     (hz.exe_dest),
    .exe_wb_en_i    (hz.exe_wb_en),
    .exe_mem_read_i (hz.exe_mem_read),
    .mem_dest_i     (hz.mem_dest),
    .mem_wb_en_i    (hz.mem_wb_en),
    .fwd_en_i       (hz.fwd_en),
    .hazard_o       (hazard)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_all  = 1'b0;
    br_flush   = 1'b0;
    data_stall = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_d   = MEM_WAIT;
          cnt_d     = '0;
          stall_all = 1'b1;
        end else if (hz.branch_taken) begin
          br_flush = 1'b1;
        end else if (hazard) begin
          data_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Completion wins over timeout; the pipe stays frozen until the next edge.
        stall_all = 1'b1;
        cnt_d     = cnt_inc;
        if (hz.mem_ready) begin
          state_d = RUN;
        end else if (cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        stall_all = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (rst) begin
      stall_all  = 1'b0;
      br_flush   = 1'b0;
      data_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_freeze     = stall_all | data_stall;
  assign hz.ifid_freeze   = stall_all | data_stall;
  assign hz.idexe_freeze  = stall_all;
  assign hz.exemem_freeze = stall_all;
  assign hz.ifid_flush    = br_flush;
  assign hz.idexe_flush   = br_flush | data_stall;
  assign hz.memwb_flush   = stall_all;
  assign hz.mem_error     = !rst && (state_q == ERROR);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hz.pc_freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz.ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`endif
endmodule
